nrisc_data_port: RTL and testbench
==================================

// Module: nrisc_data_port
// PURPOSE
//  Data-memory responder for the NRISC core's data-side command signals.
//  Latches an address on the core's address strobe, then serves a load or a write.
//  Each access takes a fixed, programmable number of wait states.
//  Returns read data with a one-cycle ready pulse; sits between the core/REGs and the data RAM.
// PARAMETERS
//  TAM          16   data/address word width (same as core and ULA)
//  ADDR_W       8    internal RAM address bits; DEPTH = 2**ADDR_W words
//  WAIT_CYCLES  1    wait states inserted per access (0..15)
// PORTS
//  clk            in   1       main clock, rising edge
//  rst            in   1       asynchronous, active-low reset
//  DATA_ADDR_clk  in   1       address strobe: latch DATA_addr this cycle
//  DATA_addr      in   TAM     address from register file (RF1)
//  DATA_wdata     in   TAM     write data from register file (RF2)
//  DATA_load      in   1       load request (level, sampled in IDLE)
//  DATA_write     in   1       write request (level, sampled in IDLE)
//  DATA_rdata     out  TAM     load result to the REGs data mux
//  DATA_ready     out  1       1-cycle pulse: access complete
//  DATA_busy      out  1       access in progress; new commands ignored
//  DATA_err       out  1       1-cycle pulse: protocol or range error
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE, addr_q=0, wait counter=0.
//   All outputs are 0. RAM contents are not cleared.
//   Reset during BUSY aborts the access; a pending write is not committed.
//  FSM states: IDLE, BUSY, DONE.
//  Address strobe in IDLE with DATA_ADDR_clk=1: addr_q <= DATA_addr at that edge.
//   The strobe may coincide with a command; the command then uses the new address.
//  Address strobe in BUSY/DONE: ignored; DATA_err pulses the next cycle.
//  IDLE, exactly one of load/write high at edge N:
//   - Capture op and wdata.
//   - If WAIT_CYCLES>0, go to BUSY with cnt=WAIT_CYCLES-1; otherwise go to DONE.
//  BUSY: decrement cnt each cycle; go to DONE when cnt==0.
//  DONE (one cycle):
//   - DATA_ready=1.
//   - Write commits to RAM at the exit edge; a load drives DATA_rdata=RAM[addr_q].
//   - Return to IDLE.
//  Latency: DATA_ready is high in cycle N+1+WAIT_CYCLES.
//  DATA_busy=1 in BUSY and DONE.
//  DATA_rdata holds its last load value until the next load completes; a write leaves it unchanged.
//  Both load and write high in IDLE: no access, stay IDLE, DATA_err pulses.
//  Out of range (addr_q[TAM-1:ADDR_W]!=0): full latency runs and DATA_ready still pulses.
//   DATA_err also pulses in the same cycle.
//   Loads return 0; writes are dropped.
//  Commands stay level-sensitive. A request held high after DONE starts a new access from IDLE.
//   The core must drop the request in the DATA_ready cycle.
// CONFIGURATION
//  NRISC_DATA_AUTOINC_EN defined:
//   - At DONE of every in-range access, addr_q <= addr_q+1, wrapping at 2**ADDR_W.
//   - Upper bits are cleared, so sequential stack/array walks need no address strobe.
//   - An address strobe in the IDLE cycle after DONE overrides the increment.
//  NRISC_DATA_AUTOINC_EN not defined: addr_q changes only on an address strobe.
// STRUCTURE
//  nrisc_pkg holds: the state encoding (IDLE/BUSY/DONE), the op encoding (OP_LOAD/OP_WRITE) and default TAM.
//  Sub-module nrisc_dmem_array: DEPTH x TAM RAM, synchronous write, asynchronous read.
//   It has no reset and is instantiated once.
//  FSM, counter, address register and error logic live in nrisc_data_port.
// TESTING
//  1. WAIT_CYCLES=1: strobe addr 0x0005; write 0xBEEF; then load.
//     -> ready at N+2 for each access; rdata=0xBEEF; err=0.
//  2. WAIT_CYCLES=0: load addr 0x00FF holding 0x1234.
//     -> ready at N+1, rdata=0x1234, busy high for 1 cycle.
//  3. load=write=1 in IDLE -> err pulse; no ready; RAM unchanged; state IDLE.
//  4. Strobe 0x0100 then write 0xAAAA.
//     -> ready and err in the same cycle; a load from 0x0000 is unaffected; a load from 0x0100 returns 0.
//  5. WAIT_CYCLES=3: write started, rst=0 in the 2nd BUSY cycle.
//     -> all outputs 0 immediately; RAM word unchanged.
//  6. AUTOINC_EN: strobe 0x00FF; write 0x1111; write 0x2222.
//     -> RAM[0xFF]=0x1111, RAM[0x00]=0x2222 (wrap).

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared encodings for the NRISC data-side port: FSM states, access op and
// the default data/address word width.
package nrisc_pkg;

   localparam int TAM_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dp_state_t;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_WRITE = 1'b1
   } dp_op_t;

endpackage

// File: rtl/nrisc_dmem_array.sv
// Data RAM behind the NRISC data port: DEPTH x TAM words, synchronous write,
// asynchronous read. No reset; contents survive a port reset.
module nrisc_dmem_array
   import nrisc_pkg::*;
#(
   parameter int TAM    = TAM_DEF,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [TAM-1:0]    wdata,
   output logic [TAM-1:0]    rdata
);

   logic [TAM-1:0] mem [2**ADDR_W];

   // Write port: one word per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/nrisc_data_port.sv
// NRISC data-memory responder: latches an address on the strobe, then serves
// one load or write with WAIT_CYCLES wait states and a one-cycle ready pulse.
// Optional feature: NRISC_DATA_AUTOINC_EN (post-increment of the address after
// every in-range access, wrapping within the RAM).
//
//  state | meaning
//  IDLE  | accepts address strobe and a single load/write request
//  BUSY  | wait states; down-counter runs to terminal count 0
//  DONE  | one cycle: ready pulse, write commits / load result returned
module nrisc_data_port
   import nrisc_pkg::*;
#(
   parameter int TAM         = TAM_DEF,
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           DATA_ADDR_clk,
   input  logic [TAM-1:0] DATA_addr,
   input  logic [TAM-1:0] DATA_wdata,
   input  logic           DATA_load,
   input  logic           DATA_write,
   output logic [TAM-1:0] DATA_rdata,
   output logic           DATA_ready,
   output logic           DATA_busy,
   output logic           DATA_err
);

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dp_state_t      state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [TAM-1:0] addr_q;
   dp_op_t         op_q;
   logic [TAM-1:0] wdata_q;
   logic [TAM-1:0] rdata_q;
   logic           err_q;

   logic           cmd_one;
   logic           cmd_both;
   logic           oor;
   logic           ram_we;
   logic [TAM-1:0] ram_rdata;
   logic [TAM-1:0] load_val;

   assign cmd_one  = DATA_load ^ DATA_write;
   assign cmd_both = DATA_load & DATA_write;
   assign oor      = |addr_q[TAM-1:ADDR_W];
   assign ram_we   = (state_q == DONE) && (op_q == OP_WRITE) && !oor;
   assign load_val = oor ? '0 : ram_rdata;

   nrisc_dmem_array #(
      .TAM    (TAM),
      .ADDR_W (ADDR_W)
   ) u_dmem (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_q[ADDR_W-1:0]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (cmd_one) begin
               if (WAIT_CYCLES > 0) begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Address register: strobe in IDLE wins; optional post-increment after DONE.
`ifdef NRISC_DATA_AUTOINC_EN
   logic [ADDR_W-1:0] addr_inc;
   assign addr_inc = addr_q[ADDR_W-1:0] + ADDR_W'(1);
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q <= '0;
      end else if ((state_q == IDLE) && DATA_ADDR_clk) begin
         addr_q <= DATA_addr;
      end
`ifdef NRISC_DATA_AUTOINC_EN
      else if ((state_q == DONE) && !oor) begin
         addr_q <= {{(TAM-ADDR_W){1'b0}}, addr_inc};
      end
`endif
   end

   // Command capture, load result hold register and registered protocol error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_LOAD;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state_q == IDLE) && cmd_one) begin
            op_q    <= DATA_write ? OP_WRITE : OP_LOAD;
            wdata_q <= DATA_wdata;
         end
         if ((state_q == DONE) && (op_q == OP_LOAD)) rdata_q <= load_val;
         err_q <= ((state_q != IDLE) && DATA_ADDR_clk) || ((state_q == IDLE) && cmd_both);
      end
   end

   assign DATA_ready = (state_q == DONE);
   assign DATA_busy  = (state_q != IDLE);
   assign DATA_err   = err_q | (DATA_ready & oor);
   // Load data is visible in the ready cycle itself, then held.
   assign DATA_rdata = (DATA_ready && (op_q == OP_LOAD)) ? load_val : rdata_q;

endmodule

// File: tb/tb_nrisc_data_port.sv
// Bench for nrisc_data_port: three instances with WAIT_CYCLES = 0, 1, 3.
// Index 0 -> W=0, index 1 -> W=1, index 2 -> W=3.
module tb_nrisc_data_port;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [2:0]       stb = '0;
   logic [2:0]       ld  = '0;
   logic [2:0]       wr  = '0;
   logic [2:0][15:0] addr  = '0;
   logic [2:0][15:0] wdata = '0;
   logic [2:0][15:0] rdata;
   logic [2:0]       ready;
   logic [2:0]       busy;
   logic [2:0]       err;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   nrisc_data_port #(.TAM(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .DATA_ADDR_clk(stb[0]), .DATA_addr(addr[0]),
      .DATA_wdata(wdata[0]), .DATA_load(ld[0]), .DATA_write(wr[0]),
      .DATA_rdata(rdata[0]), .DATA_ready(ready[0]), .DATA_busy(busy[0]), .DATA_err(err[0]));

   nrisc_data_port #(.TAM(16), .ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .DATA_ADDR_clk(stb[1]), .DATA_addr(addr[1]),
      .DATA_wdata(wdata[1]), .DATA_load(ld[1]), .DATA_write(wr[1]),
      .DATA_rdata(rdata[1]), .DATA_ready(ready[1]), .DATA_busy(busy[1]), .DATA_err(err[1]));

   nrisc_data_port #(.TAM(16), .ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .DATA_ADDR_clk(stb[2]), .DATA_addr(addr[2]),
      .DATA_wdata(wdata[2]), .DATA_load(ld[2]), .DATA_write(wr[2]),
      .DATA_rdata(rdata[2]), .DATA_ready(ready[2]), .DATA_busy(busy[2]), .DATA_err(err[2]));

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One access on instance d; inputs change on the falling edge.
   task automatic access(input int d, input logic s, input logic [15:0] a,
                         input logic is_load, input logic [15:0] wd,
                         input int exp_lat, input logic [15:0] exp_rd,
                         input logic exp_err, input string nm);
      int lat;
      @(negedge clk);
      stb[d] = s; addr[d] = a; wdata[d] = wd;
      ld[d] = is_load; wr[d] = !is_load;
      @(negedge clk);
      stb[d] = 1'b0; ld[d] = 1'b0; wr[d] = 1'b0;
      lat = 1;
      while (!ready[d] && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 16'(lat), 16'(exp_lat));
      chk({nm, " rdata"}, rdata[d], exp_rd);
      chk({nm, " err"}, {15'd0, err[d]}, {15'd0, exp_err});
      chk({nm, " busy@ready"}, {15'd0, busy[d]}, 16'd1);
      @(negedge clk);
      chk({nm, " idle after"}, {14'd0, ready[d], busy[d]}, 16'd0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic        is_load;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int lat;
      // every entry strobes its own address, so it holds with or without autoinc
      tbl[0] = '{16'h0005, 1'b0, 16'hBEEF, 16'h0000, 1'b0};
      tbl[1] = '{16'h0005, 1'b1, 16'h0000, 16'hBEEF, 1'b0};
      tbl[2] = '{16'h0000, 1'b0, 16'h1234, 16'hBEEF, 1'b0};
      tbl[3] = '{16'h0100, 1'b0, 16'hAAAA, 16'hBEEF, 1'b1};
      tbl[4] = '{16'h0000, 1'b1, 16'h0000, 16'h1234, 1'b0};
      tbl[5] = '{16'h0100, 1'b1, 16'h0000, 16'h0000, 1'b1};
      tbl[6] = '{16'h8005, 1'b1, 16'h0000, 16'h0000, 1'b1};
      tbl[7] = '{16'h0005, 1'b1, 16'h0000, 16'hBEEF, 1'b0};

      // reset state
      #12;
      chk("reset outputs", {rdata[1][12:0], ready[1], busy[1], err[1]}, 16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         access(1, 1'b1, tbl[i].a, tbl[i].is_load, tbl[i].wd, 2,
                tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));

      // load and write together: err next cycle, no access, RAM untouched
      @(negedge clk);
      stb[1] = 1'b1; addr[1] = 16'h0005; ld[1] = 1'b1; wr[1] = 1'b1; wdata[1] = 16'hDEAD;
      @(negedge clk);
      stb[1] = 1'b0; ld[1] = 1'b0; wr[1] = 1'b0;
      chk("both err", {15'd0, err[1]}, 16'd1);
      chk("both no ready/busy", {14'd0, ready[1], busy[1]}, 16'd0);
      @(negedge clk);
      chk("both err one cycle", {13'd0, err[1], ready[1], busy[1]}, 16'd0);
      access(1, 1'b0, 16'h0000, 1'b1, 16'h0, 2, 16'hBEEF, 1'b0, "both ram intact");

      // address post-increment (or its absence)
      access(1, 1'b1, 16'h00FF, 1'b0, 16'h1111, 2, 16'hBEEF, 1'b0, "inc w1");
      access(1, 1'b0, 16'h0000, 1'b0, 16'h2222, 2, 16'hBEEF, 1'b0, "inc w2");
`ifdef NRISC_DATA_AUTOINC_EN
      access(1, 1'b1, 16'h00FF, 1'b1, 16'h0, 2, 16'h1111, 1'b0, "inc rd ff");
      access(1, 1'b1, 16'h0000, 1'b1, 16'h0, 2, 16'h2222, 1'b0, "inc rd 00");
`else
      access(1, 1'b1, 16'h00FF, 1'b1, 16'h0, 2, 16'h2222, 1'b0, "noinc rd ff");
`endif

      // zero wait states
      access(0, 1'b1, 16'h00FF, 1'b0, 16'h1234, 1, 16'h0000, 1'b0, "w0 write");
      access(0, 1'b1, 16'h00FF, 1'b1, 16'h0000, 1, 16'h1234, 1'b0, "w0 load");

      // strobe while busy: err next cycle, access completes on the old address
      access(2, 1'b1, 16'h0010, 1'b0, 16'h7777, 4, 16'h0000, 1'b0, "w3 write");
      @(negedge clk);
      stb[2] = 1'b1; addr[2] = 16'h0010; ld[2] = 1'b1;
      @(negedge clk);
      ld[2] = 1'b0; stb[2] = 1'b1; addr[2] = 16'h0020;
      @(negedge clk);
      stb[2] = 1'b0;
      chk("busy strobe err", {15'd0, err[2]}, 16'd1);
      lat = 2;
      while (!ready[2] && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk("busy strobe latency", 16'(lat), 16'd4);
      chk("busy strobe rdata", rdata[2], 16'h7777);
      chk("busy strobe err cleared", {15'd0, err[2]}, 16'd0);
      @(negedge clk);

      // reset in the 2nd BUSY cycle of a write aborts it
      @(negedge clk);
      stb[2] = 1'b1; addr[2] = 16'h0010; wr[2] = 1'b1; wdata[2] = 16'h9999;
      @(negedge clk);
      stb[2] = 1'b0; wr[2] = 1'b0;
      chk("pre-reset busy", {15'd0, busy[2]}, 16'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset busy/ready/err", {13'd0, busy[2], ready[2], err[2]}, 16'd0);
      chk("reset rdata", rdata[2], 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      access(2, 1'b1, 16'h0010, 1'b1, 16'h0, 4, 16'h7777, 1'b0, "post-reset ram");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
